sd2_pipelined_divider: RTL and testbench
========================================

Name: sd2_pipelined_divider

Overview:
- Fully pipelined signed integer divider that accepts one N-bit two's-complement dividend/divisor pair every clock.
- Returns the C-style truncating quotient and remainder a fixed number of cycles later.
- Used as a datapath arithmetic unit. Internally it is a non-restoring, signed-digit (radix-2) division array built from sign, negate, absolute/propagate and final-adjust cells, with one pipeline register per quotient row.
- The internal digit encoding is free, provided the results below hold.

Parameters:
- N, 4, operand/result width in bits (N >= 3).
- LATENCY, N+2 (derived, not overridable), cycles from the input-sampling edge to the edge that updates z/r.

Ports:
- clock  input  1  rising-edge clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- x      input  N  dividend, two's complement, sampled every rising edge.
- y      input  N  divisor, two's complement, sampled every rising edge.
- z      output N  registered quotient, two's complement.
- r      output N  registered remainder, two's complement.

Behaviour:
- Reset
  - While reset = 0: every pipeline register, z and r are forced to 0 immediately, independent of the clock.
  - The first rising edge after reset deasserts samples x/y normally.
  - Garbage never propagates: stages that have not yet received a post-reset sample output 0/0.
- Throughput and latency
  - A new operand pair is accepted every cycle; there is no handshake and no stall.
  - A pair sampled at edge k appears on z/r just after edge k+LATENCY. For N=4 that is 6 edges.
  - Results exit strictly in issue order.
- Arithmetic (x, y signed N-bit)
  - z = trunc(x/y), rounded toward zero.
  - r = x - z*y.
  - r = 0, or sign(r) = sign(x).
  - |r| < |y|.
- Overflow: x = -2^(N-1), y = -1 gives z = -2^(N-1) (wrap-around) and r = 0.
- Division by zero (y = 0), a decided behaviour: z = all ones (-1) and r = x. No error flag.
- Final-step correction
  - When the non-restoring remainder has the wrong sign relative to x, or equals ±|y|, the adjust stage corrects the quotient by ±1 and the remainder by ∓y.
  - A remainder that is exactly zero after correction must give an exact quotient.
  - Example: -8/4 = -2, r 0, never -1 r -4.
- Mid-stream reset: asserting reset with operands in flight discards all of them. Outputs read 0 until a new pair has traversed the full pipeline.

Test Plan:
- N=4, back-to-back issue after reset release: (7,3), (10,4), (-13,4), (-120,11). These truncate to 4-bit patterns (7,3), (-6,4), (3,4), (-8,-5). Required outputs, at cycles 6, 7, 8, 9 after issue: z/r = 2/1, -1/-2, 0/3, 1/-3.
- N=4 exhaustive: all x in [-8,7] and y ≠ 0, one pair per cycle. Each output must equal trunc(x/y) and x%y exactly LATENCY cycles later. Include -8/-1 -> z=-8, r=0, and exact cases -8/4 -> -2/0 and 6/-3 -> -2/0.
- Division by zero: x=5, y=0 -> z=-1, r=5; x=-3, y=0 -> z=-1, r=-3.
- Reset behaviour:
  - Assert reset mid-stream, asynchronously between edges: z/r drop to 0 immediately.
  - After release, outputs stay 0 until the first new pair arrives 6 cycles later.
- N=8 sanity: 100/7 -> 14/2; -100/7 -> -14/-2; 100/-7 -> -14/2; -128/-1 -> -128/0; 127/127 -> 1/0. Each result appears 10 cycles after issue.

Source files
------------

// File: rtl/sd2_pipelined_divider.sv
// Fully pipelined signed integer divider (C-style truncating quotient and remainder).
// Pipeline: operand capture -> sign/absolute cell -> N non-restoring rows -> final adjust.
// A pair sampled at edge k updates z/r at edge k+N+2.
module sd2_pipelined_divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] z,
    output logic [N-1:0] r
);

    // Partial remainder width: |p| stays below 2*|y| <= 2^N, plus sign.
    localparam int W = N + 2;

    // Operand capture stage
    logic [N-1:0] x_r;
    logic [N-1:0] y_r;
    logic         v_in_r;

    // Per-row pipeline state, index 0 is the sign/absolute stage
    logic [W-1:0] p_r  [0:N];   // signed partial remainder
    logic [N-1:0] aq_r [0:N];   // unconsumed dividend bits (high) / quotient bits (low)
    logic [N-1:0] d_r  [0:N];   // divisor magnitude
    logic         sx_r [0:N];   // dividend sign, gives remainder sign
    logic         sq_r [0:N];   // quotient sign
    logic         dz_r [0:N];   // divide by zero
    logic         v_r  [0:N];   // stage holds a post-reset sample

    logic [N-1:0] ax_s;
    logic [N-1:0] ay_s;
    logic [N-1:0] rem_s;
    logic [N-1:0] q_s;

    // One non-restoring row: shift in the next dividend bit, add or subtract
    // the divisor depending on the current remainder sign, emit a quotient digit.
    // A digit of 1 means the new remainder is non-negative, so the collected
    // digits already form the restoring quotient.
    function automatic logic [W+N-1:0] row_step(
        input logic [W-1:0] p,
        input logic [N-1:0] aq,
        input logic [N-1:0] d
    );
        logic [W-1:0] p_sh;
        logic [W-1:0] p_nx;
        p_sh = {p[W-2:0], aq[N-1]};
        if (p[W-1]) begin
            p_nx = p_sh + {2'b00, d};
        end else begin
            p_nx = p_sh - {2'b00, d};
        end
        return {p_nx, aq[N-2:0], ~p_nx[W-1]};
    endfunction

    // Magnitudes; -2^(N-1) maps onto itself, which reads correctly as unsigned 2^(N-1).
    assign ax_s = x_r[N-1] ? -x_r : x_r;
    assign ay_s = y_r[N-1] ? -y_r : y_r;

    // Final adjust: a negative non-restoring remainder gets the divisor added back.
    // The result lies in [0, |y|), so the low N bits are sufficient.
    assign rem_s = p_r[N][N-1:0] + (p_r[N][W-1] ? d_r[N] : {N{1'b0}});
    assign q_s   = aq_r[N];

    // Capture operands every edge; the valid bit marks post-reset samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r    <= {N{1'b0}};
            y_r    <= {N{1'b0}};
            v_in_r <= 1'b0;
        end else begin
            x_r    <= x;
            y_r    <= y;
            v_in_r <= 1'b1;
        end
    end

    // Sign/absolute stage followed by the N division rows, one register per row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= N; i++) begin
                p_r[i]  <= {W{1'b0}};
                aq_r[i] <= {N{1'b0}};
                d_r[i]  <= {N{1'b0}};
                sx_r[i] <= 1'b0;
                sq_r[i] <= 1'b0;
                dz_r[i] <= 1'b0;
                v_r[i]  <= 1'b0;
            end
        end else begin
            p_r[0]  <= {W{1'b0}};
            aq_r[0] <= ax_s;
            d_r[0]  <= ay_s;
            sx_r[0] <= x_r[N-1];
            sq_r[0] <= x_r[N-1] ^ y_r[N-1];
            dz_r[0] <= (y_r == {N{1'b0}});
            v_r[0]  <= v_in_r;
            for (int i = 1; i <= N; i++) begin
                {p_r[i], aq_r[i]} <= row_step(p_r[i-1], aq_r[i-1], d_r[i-1]);
                d_r[i]  <= d_r[i-1];
                sx_r[i] <= sx_r[i-1];
                sq_r[i] <= sq_r[i-1];
                dz_r[i] <= dz_r[i-1];
                v_r[i]  <= v_r[i-1];
            end
        end
    end

    // Output stage: apply signs, divide-by-zero result, and hold 0/0 for empty stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            z <= {N{1'b0}};
            r <= {N{1'b0}};
        end else if (!v_r[N]) begin
            z <= {N{1'b0}};
            r <= {N{1'b0}};
        end else if (dz_r[N]) begin
            // Remainder equals |x| here, so restoring its sign returns x itself.
            z <= {N{1'b1}};
            r <= sx_r[N] ? -rem_s : rem_s;
        end else begin
            z <= sq_r[N] ? -q_s : q_s;
            r <= sx_r[N] ? -rem_s : rem_s;
        end
    end

endmodule

// File: tb/tb_sd2_pipelined_divider.sv
// Self-checking bench: N=4 and N=8 instances, directed vector table, exhaustive
// N=4 sweep, random N=8 stimulus against an arithmetic reference, reset sequences.
module tb_sd2_pipelined_divider;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] x4, y4, z4, r4;
    logic [7:0] x8, y8, z8, r8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic [3:0] z; logic [3:0] r;} e4_t;
    typedef struct packed {logic [7:0] z; logic [7:0] r;} e8_t;
    typedef struct {
        int x4; int y4; int z4; int r4;
        int x8; int y8; int z8; int r8;
    } vec_t;

    e4_t  q4[$];
    e8_t  q8[$];
    vec_t tbl[12];

    sd2_pipelined_divider #(.N(4)) dut4 (.clock(clock), .reset(reset), .x(x4), .y(y4), .z(z4), .r(r4));
    sd2_pipelined_divider #(.N(8)) dut8 (.clock(clock), .reset(reset), .x(x8), .y(y8), .z(z8), .r(r8));

    always #5 clock = ~clock;

    function automatic logic [3:0] t4(input int v);
        logic [31:0] w;
        w = v;
        return w[3:0];
    endfunction

    function automatic logic [7:0] t8(input int v);
        logic [31:0] w;
        w = v;
        return w[7:0];
    endfunction

    // Reference: wrap operands to n-bit signed, then C-style division.
    function automatic void ref_div(input int a, input int b, input int n, output int zq, output int rm);
        int xs;
        int ys;
        int m;
        m  = 32'sd1 << n;
        xs = a & (m - 32'sd1);
        ys = b & (m - 32'sd1);
        if (xs >= m / 32'sd2) xs = xs - m;
        if (ys >= m / 32'sd2) ys = ys - m;
        if (ys == 32'sd0) begin
            zq = -32'sd1;
            rm = xs;
        end else begin
            zq = xs / ys;
            rm = xs % ys;
        end
    endfunction

    task automatic check4(input e4_t e, input string nm);
        checks++;
        if (z4 !== e.z || r4 !== e.r) begin
            errors++;
            $display("FAIL %s: got z=%0d r=%0d, want z=%0d r=%0d @%0t", nm,
                     $signed(z4), $signed(r4), $signed(e.z), $signed(e.r), $time);
        end
    endtask

    task automatic check8(input e8_t e, input string nm);
        checks++;
        if (z8 !== e.z || r8 !== e.r) begin
            errors++;
            $display("FAIL %s: got z=%0d r=%0d, want z=%0d r=%0d @%0t", nm,
                     $signed(z8), $signed(r8), $signed(e.z), $signed(e.r), $time);
        end
    endtask

    // Empty pipeline after reset release: outputs read 0/0 until the first pair emerges.
    task automatic prefill();
        q4.delete();
        q8.delete();
        repeat (6)  q4.push_back(8'h00);
        repeat (10) q8.push_back(16'h0000);
    endtask

    // Drive one pair per instance (called at the falling edge), record the
    // expected result, and compare the pair that left the pipeline on this edge.
    task automatic tick(input int a4, input int b4, input int ez4, input int er4,
                        input int a8, input int b8, input int ez8, input int er8);
        x4 = t4(a4);
        y4 = t4(b4);
        x8 = t8(a8);
        y8 = t8(b8);
        @(posedge clock);
        q4.push_back({t4(ez4), t4(er4)});
        q8.push_back({t8(ez8), t8(er8)});
        @(negedge clock);
        if (q4.size() > 6)  check4(q4.pop_front(), "n4_result");
        if (q8.size() > 10) check8(q8.pop_front(), "n8_result");
    endtask

    task automatic tick_model(input int a4, input int b4);
        int a8, b8, ez4, er4, ez8, er8;
        a8 = int'($urandom_range(0, 255));
        b8 = int'($urandom_range(0, 255));
        ref_div(a4, b4, 4, ez4, er4);
        ref_div(a8, b8, 8, ez8, er8);
        tick(a4, b4, ez4, er4, a8, b8, ez8, er8);
    endtask

    initial begin
        tbl[0]  = '{7,    3,   2,  1,  100,  7,    14,   2};
        tbl[1]  = '{10,   4,  -1, -2, -100,  7,   -14,  -2};
        tbl[2]  = '{-13,  4,   0,  3,  100, -7,   -14,   2};
        tbl[3]  = '{-120, 11,  1, -3, -128, -1,  -128,   0};
        tbl[4]  = '{-8,  -1,  -8,  0,  127, 127,    1,   0};
        tbl[5]  = '{-8,   4,  -2,  0,    0,  5,     0,   0};
        tbl[6]  = '{6,   -3,  -2,  0,   -1,  2,     0,  -1};
        tbl[7]  = '{5,    0,  -1,  5,    7,  0,    -1,   7};
        tbl[8]  = '{-3,   0,  -1, -3, -128,  0,    -1, -128};
        tbl[9]  = '{-8,   0,  -1, -8, -128, 127,   -1,  -1};
        tbl[10] = '{7,   -8,   0,  7,  127, -128,   0, 127};
        tbl[11] = '{-7,   2,  -3, -1, -127, -128,   0, -127};

        reset = 1'b0;
        x4 = 4'h0; y4 = 4'h0; x8 = 8'h00; y8 = 8'h00;
        repeat (2) @(negedge clock);
        check4(8'h00, "reset_n4");
        check8(16'h0000, "reset_n8");

        reset = 1'b1;
        prefill();

        // Directed vectors issued back to back
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].x4, tbl[i].y4, tbl[i].z4, tbl[i].r4,
                 tbl[i].x8, tbl[i].y8, tbl[i].z8, tbl[i].r8);
        end

        // Exhaustive N=4 sweep (y != 0), random N=8 operands alongside
        for (int a = -8; a <= 7; a++) begin
            for (int b = -8; b <= 7; b++) begin
                if (b != 0) tick_model(a, b);
            end
        end

        // Asynchronous reset between edges with results in flight
        #2;
        reset = 1'b0;
        #1;
        check4(8'h00, "async_reset_n4");
        check8(16'h0000, "async_reset_n8");
        @(posedge clock);
        @(negedge clock);
        check4(8'h00, "reset_hold_n4");
        check8(16'h0000, "reset_hold_n8");

        // Release: zeros until new pairs traverse the full pipeline, then results
        reset = 1'b1;
        prefill();
        for (int i = 0; i < 40; i++) begin
            tick_model(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
